// File: rtl/regfile_tagged.sv
// Architectural register file with per-register rename state (busy bit plus the
// youngest producer's ROB tag). Two combinational read ports bypass a same-cycle commit.
module regfile_tagged #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [TAG_WIDTH-1:0]  iss_tag,
  input  logic                  cmt_valid,
  input  logic [ADDR_WIDTH-1:0] cmt_rd,
  input  logic [TAG_WIDTH-1:0]  cmt_tag,
  input  logic [DATA_WIDTH-1:0] cmt_data,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [TAG_WIDTH-1:0]  rs1_tag,
  output logic [TAG_WIDTH-1:0]  rs2_tag,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] data_r     [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_r      [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_nxt_s  [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   busy_nxt_s;
  logic [CNT_W-1:0]      busy_cnt_r;
  logic                  cmt_en_s;
  logic                  iss_en_s;
  logic                  flush_en_s;
  logic                  cmt_hit_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Qualify requests; register 0 is hardwired and ignores issue and commit.
  always_comb begin
    cmt_en_s   = rdy & cmt_valid & (cmt_rd != {ADDR_WIDTH{1'b0}});
    iss_en_s   = rdy & iss_valid & (iss_rd != {ADDR_WIDTH{1'b0}}) & ~flush;
    flush_en_s = rdy & flush;
    // A commit only retires the register if it is still the youngest producer.
    cmt_hit_s  = cmt_en_s & busy_r[cmt_rd] & (tag_r[cmt_rd] == cmt_tag);
  end

  // Next rename state: flush beats issue, issue beats the commit clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_nxt_s[i] = tag_r[i];
      if (flush_en_s) begin
        busy_nxt_s[i] = 1'b0;
      end else if (iss_en_s && (iss_rd == ADDR_WIDTH'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (cmt_hit_s && (cmt_rd == ADDR_WIDTH'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
      if (iss_en_s && (iss_rd == ADDR_WIDTH'(i))) begin
        tag_nxt_s[i] = iss_tag;
      end else begin
        tag_nxt_s[i] = tag_r[i];
      end
    end
  end

  // Rename state and busy counter; every enable above is gated by rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= {NUM_REGS{1'b0}};
      busy_cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_r[i] <= {TAG_WIDTH{1'b0}};
      end
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= popcount(busy_nxt_s);
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_r[i] <= tag_nxt_s[i];
      end
    end
  end

  // Committed values; the data write happens even for stale tags and under flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cmt_en_s && (cmt_rd == ADDR_WIDTH'(i))) begin
          data_r[i] <= cmt_data;
        end
      end
    end
  end

  // Read port 1 with commit bypass.
  always_comb begin
    rs1_data = data_r[rs1_addr];
    rs1_busy = busy_r[rs1_addr];
    rs1_tag  = tag_r[rs1_addr];
    if (rs1_addr == {ADDR_WIDTH{1'b0}}) begin
      rs1_data = {DATA_WIDTH{1'b0}};
      rs1_busy = 1'b0;
      rs1_tag  = {TAG_WIDTH{1'b0}};
    end else if (cmt_hit_s && (rs1_addr == cmt_rd)) begin
      rs1_data = cmt_data;
      rs1_busy = 1'b0;
    end else begin
      rs1_data = data_r[rs1_addr];
      rs1_busy = busy_r[rs1_addr];
    end
  end

  // Read port 2 with commit bypass.
  always_comb begin
    rs2_data = data_r[rs2_addr];
    rs2_busy = busy_r[rs2_addr];
    rs2_tag  = tag_r[rs2_addr];
    if (rs2_addr == {ADDR_WIDTH{1'b0}}) begin
      rs2_data = {DATA_WIDTH{1'b0}};
      rs2_busy = 1'b0;
      rs2_tag  = {TAG_WIDTH{1'b0}};
    end else if (cmt_hit_s && (rs2_addr == cmt_rd)) begin
      rs2_data = cmt_data;
      rs2_busy = 1'b0;
    end else begin
      rs2_data = data_r[rs2_addr];
      rs2_busy = busy_r[rs2_addr];
    end
  end

  assign busy_cnt = busy_cnt_r;

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file with per-register rename status for the out-of-order core. It holds committed register values and, for each register, a busy bit plus the reorder-buffer tag of the youngest in-flight producer. The block sits between decode/issue, which reads operands and claims destinations, and ROB commit, which writes results back. Two combinational read ports bypass a same-cycle commit.

## Interface
Parameters:
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- TAG_WIDTH, 4, ROB tag width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; low freezes all state
- iss_valid  in  1  claim destination this cycle
- iss_rd  in  ADDR_WIDTH  destination register
- iss_tag  in  TAG_WIDTH  ROB tag of the new producer
- cmt_valid  in  1  commit write this cycle
- cmt_rd  in  ADDR_WIDTH  committed destination
- cmt_tag  in  TAG_WIDTH  ROB tag of the committing entry
- cmt_data  in  DATA_WIDTH  committed value
- flush  in  1  misprediction recovery; clear all busy bits
- rs1_addr, rs2_addr  in  ADDR_WIDTH  read addresses
- rs1_data, rs2_data  out  DATA_WIDTH  operand value (valid when busy=0)
- rs1_busy, rs2_busy  out  1  operand still pending
- rs1_tag, rs2_tag  out  TAG_WIDTH  producer tag (valid when busy=1)
- busy_cnt  out  ADDR_WIDTH+1  registered count of busy registers

## Operation
- State: data[NUM_REGS], busy[NUM_REGS], tag[NUM_REGS], busy_cnt.
- Reset (async, any time, including mid-operation): all data, busy and tag bits 0; busy_cnt 0.
- Register 0: reads return data 0, busy 0, tag 0; issue and commit to index 0 are ignored entirely.
- Updates happen only on a rising clk edge with rdy=1.
- Commit: data[cmt_rd] <= cmt_data unconditionally. busy[cmt_rd] is cleared only if busy[cmt_rd]=1 and tag[cmt_rd]==cmt_tag; otherwise a younger producer owns the register and its busy/tag are kept.
- Issue: busy[iss_rd] <= 1, tag[iss_rd] <= iss_tag.
- Priorities on the same register in one edge: issue over commit clear (busy stays 1, tag = iss_tag, data still written); flush over issue (issue dropped, all busy 0); flush does not block the commit data write.
- Reads are combinational from current state, before this cycle's issue takes effect, so an instruction with rd==rs sees the old mapping.
- Commit bypass applies when rdy=1, cmt_valid=1, rsX_addr==cmt_rd!=0, busy=1 and tag==cmt_tag. Then rsX_data=cmt_data and rsX_busy=0.
- Otherwise rsX_data=data[addr], rsX_busy=busy[addr], rsX_tag=tag[addr].
- busy_cnt after each edge equals the popcount of the busy bits after that edge's update. It is 0 after flush and never exceeds NUM_REGS-1.

## Timing
- Read ports: zero-cycle latency, purely combinational, including the bypass.
- Issue and commit: visible on the read ports in the cycle after the edge.
- busy_cnt: registered, one-cycle latency versus the inputs.
- rdy=0: no state change. Reads show stored state with no bypass. Inputs presented while rdy=0 are discarded, not queued.
- Back-to-back issue to the same rd on consecutive cycles: the latest tag wins; a commit carrying the older tag writes data only.

## Test plan
- Reset: assert rst mid-cycle after several issues -> immediately all reads give data 0 / busy 0, and busy_cnt=0.
- Issue then commit: issue rd=5, tag=3; next cycle read rs1=5 -> busy=1, tag=3, busy_cnt=1. Commit rd=5, tag=3, data=0xDEADBEEF -> same-cycle rs1_data=0xDEADBEEF with busy=0; next cycle stored value equals it and busy_cnt=0.
- Stale commit: issue r7 tag=1, then r7 tag=2, then commit r7 tag=1 data=0x11 -> data[7]=0x11, busy stays 1, tag=2. Commit tag=2 -> busy clears.
- Same-edge conflicts: issue r9 tag=4 plus commit r9 tag=4 data=0x55 -> busy=1, tag=4, data=0x55. Add flush on the next edge with issue r10 -> busy_cnt=0 and r10 not busy.
- x0 and rdy: issue/commit to r0 with data 0x1234 -> r0 reads 0, not busy. Hold rdy=0 while committing r3 data=0x77 -> r3 unchanged and no bypass.
- Fill: issue r1..r31 on consecutive cycles -> busy_cnt reaches 31. Flush -> busy_cnt=0 and data unchanged.
